// File: rtl/motor_pwm_ramp.sv
// Slot-car motor PWM generator: slew-rate-limited duty, glitch-free compare, estop override.
// The applied duty only moves on a PWM period boundary, so no pulse is ever truncated or stretched.
module motor_pwm_ramp #(
    parameter int PRESCALE  = 195,
    parameter int RAMP_DIV  = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] motor_ctrl,
    input  logic       estop,
    output logic       pwm_out,
    output logic [7:0] duty_applied,
    output logic       period_start,
    output logic       ramping
);
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  RDIV_LAST  = 8'(RAMP_DIV - 1);
    localparam logic [8:0]  STEP9      = 9'(RAMP_STEP);
    localparam logic [7:0]  STEP8      = 8'(RAMP_STEP);

    logic [15:0] presc_r;
    logic [7:0]  pwm_cnt_r;
    logic [7:0]  ramp_cnt_r;
    logic [7:0]  target_r;
    logic        tick_s;
    logic        wrap_s;
    logic        step_s;
    logic [8:0]  up_s;
    logic [8:0]  floor_s;
    logic [7:0]  duty_next_s;

    assign tick_s  = (presc_r == PRESC_LAST);
    assign wrap_s  = tick_s && (pwm_cnt_r == 8'd255);
    assign step_s  = wrap_s && (ramp_cnt_r == RDIV_LAST);
    assign ramping = (duty_applied != target_r);

    // Next ramp value, clamped to the target; 9-bit sums keep 255+step from wrapping.
    always_comb begin
        up_s        = {1'b0, duty_applied} + STEP9;
        floor_s     = {1'b0, target_r} + STEP9;
        duty_next_s = duty_applied;
        if (target_r > duty_applied) begin
            if (up_s > {1'b0, target_r}) begin
                duty_next_s = target_r;
            end else begin
                duty_next_s = up_s[7:0];
            end
        end else if (target_r < duty_applied) begin
            if ({1'b0, duty_applied} < floor_s) begin
                duty_next_s = target_r;
            end else begin
                duty_next_s = duty_applied - STEP8;
            end
        end else begin
            duty_next_s = duty_applied;
        end
    end

    // Counters, ramp state and registered outputs; estop beats any coincident wrap or step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_r      <= 16'd0;
            pwm_cnt_r    <= 8'd0;
            ramp_cnt_r   <= 8'd0;
            target_r     <= 8'd0;
            duty_applied <= 8'd0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            target_r     <= motor_ctrl;
            period_start <= wrap_s;
            if (tick_s) begin
                presc_r   <= 16'd0;
                pwm_cnt_r <= pwm_cnt_r + 8'd1;
            end else begin
                presc_r   <= presc_r + 16'd1;
            end
            if (estop) begin
                duty_applied <= 8'd0;
                ramp_cnt_r   <= 8'd0;
                pwm_out      <= 1'b0;
            end else begin
                pwm_out <= (pwm_cnt_r < duty_applied);
                if (step_s) begin
                    ramp_cnt_r   <= 8'd0;
                    duty_applied <= duty_next_s;
                end else if (wrap_s) begin
                    ramp_cnt_r   <= ramp_cnt_r + 8'd1;
                end else begin
                    ramp_cnt_r   <= ramp_cnt_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: four instances with different ramp settings share one stimulus,
// and per-period expectations are queued and matched at each period_start.
module tb_motor_pwm_ramp;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] motor_ctrl = 8'd0;
    logic       estop = 1'b0;
    logic       pwm_out [4];
    logic [7:0] duty_applied [4];
    logic       period_start [4];
    logic       ramping [4];

    typedef struct {
        int per;
        int inst;
        int duty;
        int rmp;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   per_no = 0;

    always #5 clk = ~clk;

    motor_pwm_ramp #(.PRESCALE(2), .RAMP_DIV(1), .RAMP_STEP(16)) u_a (
        .clk(clk), .reset_n(reset_n), .motor_ctrl(motor_ctrl), .estop(estop),
        .pwm_out(pwm_out[0]), .duty_applied(duty_applied[0]),
        .period_start(period_start[0]), .ramping(ramping[0]));
    motor_pwm_ramp #(.PRESCALE(2), .RAMP_DIV(1), .RAMP_STEP(100)) u_b (
        .clk(clk), .reset_n(reset_n), .motor_ctrl(motor_ctrl), .estop(estop),
        .pwm_out(pwm_out[1]), .duty_applied(duty_applied[1]),
        .period_start(period_start[1]), .ramping(ramping[1]));
    motor_pwm_ramp #(.PRESCALE(2), .RAMP_DIV(1), .RAMP_STEP(255)) u_c (
        .clk(clk), .reset_n(reset_n), .motor_ctrl(motor_ctrl), .estop(estop),
        .pwm_out(pwm_out[2]), .duty_applied(duty_applied[2]),
        .period_start(period_start[2]), .ramping(ramping[2]));
    motor_pwm_ramp #(.PRESCALE(2), .RAMP_DIV(3), .RAMP_STEP(16)) u_d (
        .clk(clk), .reset_n(reset_n), .motor_ctrl(motor_ctrl), .estop(estop),
        .pwm_out(pwm_out[3]), .duty_applied(duty_applied[3]),
        .period_start(period_start[3]), .ramping(ramping[3]));

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_p(input int per, input int inst, input int duty, input int rmp, input int hi);
        exp_t e;
        e.per = per; e.inst = inst; e.duty = duty; e.rmp = rmp; e.hi = hi;
        sb.push_back(e);
    endtask

    // Step to the next period_start, counting pwm_out highs and watching for mid-period duty changes.
    task automatic run_period(input bit chk_len);
        int       n;
        bit       seen;
        int       hi_acc [4];
        bit       mid_bad [4];
        logic [7:0] snap [4];
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hi_acc[i] = 0;
            mid_bad[i] = 1'b0;
            snap[i] = duty_applied[i];
        end
        while (!seen && n < 1100) begin
            step_clk(1);
            n++;
            seen = period_start[0];
            for (int i = 0; i < 4; i++) begin
                if (pwm_out[i] === 1'b1) hi_acc[i]++;
                if (!seen && duty_applied[i] !== snap[i]) mid_bad[i] = 1'b1;
            end
        end
        per_no++;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL period_timeout: no period_start after %0d clks, required within 1100", n);
        end
        if (chk_len) begin
            checks++;
            if (n !== 512) begin
                errors++;
                $display("FAIL period_len: period %0d lasted %0d clks, required 512", per_no, n);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mid_bad[i]) begin
                errors++;
                $display("FAIL mid_period_duty: inst %0d period %0d duty changed away from %0d", i, per_no, snap[i]);
            end
        end
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].per == per_no) begin
                checks++;
                if (duty_applied[sb[k].inst] !== 8'(sb[k].duty)) begin
                    errors++;
                    $display("FAIL duty: inst %0d period %0d duty_applied=%0d required %0d",
                             sb[k].inst, per_no, duty_applied[sb[k].inst], sb[k].duty);
                end
                checks++;
                if (ramping[sb[k].inst] !== 1'(sb[k].rmp)) begin
                    errors++;
                    $display("FAIL ramping: inst %0d period %0d ramping=%0b required %0d",
                             sb[k].inst, per_no, ramping[sb[k].inst], sb[k].rmp);
                end
                if (sb[k].hi >= 0) begin
                    checks++;
                    if (hi_acc[sb[k].inst] !== sb[k].hi) begin
                        errors++;
                        $display("FAIL high_clks: inst %0d period %0d pwm_out high %0d clks, required %0d",
                                 sb[k].inst, per_no, hi_acc[sb[k].inst], sb[k].hi);
                    end
                end
                sb.delete(k);
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({pwm_out[i], duty_applied[i], period_start[i], ramping[i]} !== 11'd0) begin
                errors++;
                $display("FAIL %s: inst %0d pwm=%0b duty=%0d ps=%0b ramping=%0b, required all 0",
                         name, i, pwm_out[i], duty_applied[i], period_start[i], ramping[i]);
            end
        end
    endtask

    task automatic do_reset(input logic [7:0] mc);
        motor_ctrl = mc;
        estop = 1'b0;
        reset_n = 1'b0;
        step_clk(2);
        check_zero_outputs("reset_state");
        reset_n = 1'b1;
        per_no = 0;
    endtask

    task automatic check_bit(input string name, input logic obs, input logic req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, obs, req);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, obs, req);
        end
    endtask

    task automatic test_reset();
        do_reset(8'd0);
        for (int p = 1; p <= 3; p++) begin
            expect_p(p, 0, 0, 0, 0);
            expect_p(p, 3, 0, 0, 0);
        end
        repeat (3) run_period(1'b1);
    endtask

    task automatic test_ramp_up();
        do_reset(8'd0);
        motor_ctrl = 8'd64;
        expect_p(1, 0, 16, 1, 0);  expect_p(2, 0, 32, 1, 32);  expect_p(3, 0, 48, 1, 64);
        expect_p(4, 0, 64, 0, 96); expect_p(5, 0, 64, 0, 128);
        expect_p(1, 1, 64, 0, 0);  expect_p(2, 1, 64, 0, 128);
        expect_p(1, 2, 64, 0, 0);
        expect_p(1, 3, 0, 1, 0);   expect_p(2, 3, 0, 1, 0);    expect_p(3, 3, 16, 1, 0);
        expect_p(4, 3, 16, 1, 32);
        repeat (5) run_period(1'b1);
    endtask

    task automatic test_step_down();
        motor_ctrl = 8'd10;
        expect_p(6, 1, 10, 0, 128); expect_p(7, 1, 10, 0, 20);
        expect_p(6, 2, 10, 0, 128);
        expect_p(6, 0, 48, 1, 128); expect_p(7, 0, 32, 1, 96);
        repeat (2) run_period(1'b1);
    endtask

    task automatic test_full_duty();
        motor_ctrl = 8'd255;
        expect_p(8, 2, 255, 0, 20);  expect_p(9, 2, 255, 0, 510); expect_p(10, 2, 255, 0, 510);
        expect_p(8, 1, 110, 1, 20);  expect_p(9, 1, 210, 1, 220); expect_p(10, 1, 255, 0, 420);
        repeat (3) run_period(1'b1);
    endtask

    task automatic test_estop();
        do_reset(8'd128);
        expect_p(8, 0, 128, 0, 224);  expect_p(9, 0, 128, 0, 256); expect_p(10, 0, 128, 0, 256);
        expect_p(9, 3, 48, 1, 64);    expect_p(10, 3, 48, 1, 96);
        repeat (10) run_period(1'b1);
        step_clk(100);
        check_bit("estop_pre_pwm", pwm_out[0], 1'b1);
        estop = 1'b1;
        step_clk(1);
        estop = 1'b0;
        check_bit("estop_pwm", pwm_out[0], 1'b0);
        check_byte("estop_duty", duty_applied[0], 8'd0);
        check_bit("estop_ramping", ramping[0], 1'b1);
        check_byte("estop_duty_div3", duty_applied[3], 8'd0);
        expect_p(11, 0, 16, 1, -1); expect_p(12, 0, 32, 1, 32); expect_p(13, 0, 48, 1, 64);
        expect_p(11, 3, 0, 1, -1);  expect_p(12, 3, 0, 1, 0);   expect_p(13, 3, 16, 1, 0);
        run_period(1'b0);
        repeat (2) run_period(1'b1);
    endtask

    task automatic test_ramp_div();
        do_reset(8'd0);
        motor_ctrl = 8'd40;
        expect_p(1, 3, 0, 1, 0);   expect_p(2, 3, 0, 1, 0);   expect_p(3, 3, 16, 1, 0);
        expect_p(4, 3, 16, 1, 32); expect_p(5, 3, 16, 1, 32);
        repeat (5) run_period(1'b1);
        step_clk(20);
        motor_ctrl = 8'd8;
        step_clk(20);
        check_byte("div3_mid_duty", duty_applied[3], 8'd16);
        check_bit("div3_mid_ramping", ramping[3], 1'b1);
        expect_p(6, 3, 8, 0, -1);  expect_p(7, 3, 8, 0, 16);
        run_period(1'b0);
        run_period(1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset(8'd200);
        expect_p(1, 2, 200, 0, 0); expect_p(2, 2, 200, 0, 400);
        repeat (2) run_period(1'b1);
        step_clk(100);
        check_bit("rstmid_pre_pwm", pwm_out[2], 1'b1);
        reset_n = 1'b0;
        step_clk(1);
        check_bit("rstmid_pwm", pwm_out[2], 1'b0);
        check_byte("rstmid_duty", duty_applied[2], 8'd0);
        check_bit("rstmid_ramping", ramping[2], 1'b0);
        reset_n = 1'b1;
        per_no = 0;
        expect_p(1, 2, 200, 0, 0);
        run_period(1'b1);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_step_down();
        test_full_duty();
        test_estop();
        test_ramp_div();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations unmatched, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
